// File: rtl/wb_retire_queue_if.sv
// rtl/wb_retire_queue_if.sv - MEM to WB handshake bundle
interface wb_retire_queue_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int PCW = 32
) ();
  localparam int BUS_W = 1 + AW + DW + PCW;

  logic             valid_4;
  logic             allow_5;
  logic [BUS_W-1:0] stage_4_to_5;

  modport master (output valid_4, output stage_4_to_5, input allow_5);
  modport slave  (input valid_4, input stage_4_to_5, output allow_5);
endinterface

// File: rtl/wb_retire_queue.sv
// rtl/wb_retire_queue.sv - in-order write-back retire queue with youngest-match forwarding
module wb_retire_queue #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int PCW      = 32,
  parameter int DEPTH    = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_retire_queue_if.slave         mem,
  input  logic                     flush,
  input  logic                     rf_ready,
  output logic                     valid_5,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  output logic [PCW-1:0]           debug_wb_pc,
  output logic                     debug_wb_valid,
  input  logic [AW-1:0]            fwd_addr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int BUS_W = 1 + AW + DW + PCW;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt_q;

  logic          ent_we   [DEPTH];
  logic [AW-1:0] ent_dest [DEPTH];
  logic [DW-1:0] ent_res  [DEPTH];
  logic [PCW-1:0] ent_pc  [DEPTH];

  logic          in_we;
  logic [AW-1:0] in_dest;
  logic [DW-1:0] in_res;
  logic [PCW-1:0] in_pc;
  logic          empty, full, head_we, retire, push;

  assign in_we   = mem.stage_4_to_5[BUS_W-1];
  assign in_dest = mem.stage_4_to_5[BUS_W-2 -: AW];
  assign in_res  = mem.stage_4_to_5[PCW+DW-1 -: DW];
  assign in_pc   = mem.stage_4_to_5[PCW-1:0];

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign head_we = ent_we[rd_ptr] & ~(ZERO_REG & (ent_dest[rd_ptr] == '0));
  // Non-writing heads drain without a grant; reset also suppresses any write.
  assign retire  = ~empty & (rf_ready | ~head_we) & ~flush & ~reset;
  assign push    = mem.valid_4 & mem.allow_5 & ~flush;

  assign mem.allow_5    = ~full | retire;
  assign valid_5        = ~empty;
  assign count          = cnt_q;
  assign rf_we          = retire & head_we;
  assign rf_waddr       = ent_dest[rd_ptr] & {AW{rf_we}};
  assign rf_wdata       = ent_res[rd_ptr];
  assign debug_wb_valid = retire;
  assign debug_wb_pc    = empty ? '0 : ent_pc[rd_ptr];

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < cnt_q) && ent_we[idx] && (ent_dest[idx] == fwd_addr) &&
          !(ZERO_REG && (fwd_addr == '0))) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_res[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_we[i]   <= 1'b0;
        ent_dest[i] <= '0;
        ent_res[i]  <= '0;
        ent_pc[i]   <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        ent_we[wr_ptr]   <= in_we;
        ent_dest[wr_ptr] <= in_dest;
        ent_res[wr_ptr]  <= in_res;
        ent_pc[wr_ptr]   <= in_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (retire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(retire);
    end
  end
endmodule
